// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: takes 16-bit L/R pairs over valid/ready and serializes
// them MSB-first with the standard one-BCLK data delay, generating BCLK/LRCK locally.
`timescale 1ns/1ps
module i2s_tx #(
   parameter int DATA_W    = 16,
   parameter int BCLK_HALF = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_left,
   input  logic [DATA_W-1:0] in_right,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              bclk,
   output logic              lrck,
   output logic              sdata,
   output logic              frame_start,
   output logic              underrun
);

   localparam int FRAME_W = 2 * DATA_W;
   localparam int DIV_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int CNT_W   = $clog2(FRAME_W);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DATA_W);

   logic [DIV_W-1:0]   r_div_cnt;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic               r_bclk;
   logic               r_lrck;
   logic               r_sdata;
   logic               r_fs;
   logic               r_uf;
   logic               r_full;
   logic               r_last;
   logic [DATA_W-1:0]  r_hold_l;
   logic [DATA_W-1:0]  r_hold_r;
   logic [FRAME_W-1:0] r_frame;

   logic               w_div_end;
   logic               w_fall;
   logic               w_load;
   logic               w_accept;
   logic [CNT_W-1:0]   w_bit_next;
   logic [CNT_W-1:0]   w_sel;

   assign w_div_end  = (r_div_cnt == DIV_LAST);
   assign w_fall     = w_div_end & r_bclk;
   assign w_bit_next = (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
   assign w_load     = w_fall & (w_bit_next == '0);
   assign w_accept   = in_valid & ~r_full;
   // Slot bit k-1 lives at frame index FRAME_W-k; unused when k wraps to 0.
   assign w_sel      = CNT_LAST - w_bit_next + CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div_cnt <= '0;
         r_bit_cnt <= CNT_LAST;
         r_bclk    <= 1'b0;
         r_lrck    <= 1'b1;
         r_sdata   <= 1'b0;
         r_fs      <= 1'b0;
         r_uf      <= 1'b0;
         r_full    <= 1'b0;
         r_last    <= 1'b0;
         r_hold_l  <= '0;
         r_hold_r  <= '0;
         r_frame   <= '0;
      end else begin
         r_fs <= 1'b0;
         r_uf <= 1'b0;

         if (w_div_end) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end

         if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_lrck    <= (w_bit_next >= CNT_HALF);
            if (w_bit_next == '0)
               r_sdata <= r_last;
            else
               r_sdata <= r_frame[w_sel];
            // Keep the right LSB so it can go out after the next frame replaces r_frame.
            if (w_bit_next == CNT_LAST)
               r_last <= r_frame[0];
         end

         if (w_load) begin
            r_fs <= 1'b1;
            if (r_full) begin
               r_frame <= {r_hold_l, r_hold_r};
            end else begin
               r_frame <= '0;
               r_uf    <= 1'b1;
            end
         end

         // Accept only happens when empty and a load only drains when full, so they never collide.
         if (w_accept) begin
            r_hold_l <= in_left;
            r_hold_r <= in_right;
            r_full   <= 1'b1;
         end else if (w_load) begin
            r_full   <= 1'b0;
         end
      end
   end

   assign in_ready    = ~r_full;
   assign bclk        = r_bclk;
   assign lrck        = r_lrck;
   assign sdata       = r_sdata;
   assign frame_start = r_fs;
   assign underrun    = r_uf;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus queues expected frames, a monitor
// deserializes sdata on bclk rising edges and compares each completed frame.
`timescale 1ns/1ps
module tb_i2s_tx;

   localparam int DATA_W    = 16;
   localparam int BCLK_HALF = 2;
   localparam int FRAME_CLK = 2 * DATA_W * 2 * BCLK_HALF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] in_left = '0;
   logic [15:0] in_right = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, bclk, lrck, sdata, frame_start, underrun;

   always #5 clk = ~clk;

   i2s_tx #(.DATA_W(DATA_W), .BCLK_HALF(BCLK_HALF)) dut (
      .clk(clk), .reset(reset), .in_left(in_left), .in_right(in_right),
      .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrck(lrck),
      .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
   );

   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
      logic        uf;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   frames_checked = 0;
   logic mon_en = 1'b0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor state
   logic        prev_bclk = 1'b0;
   bit          active = 0, pend_k0 = 0, have_fs = 0, have_rise = 0;
   logic        uf_next = 1'b0, cur_uf = 1'b0;
   int          k = 0, last_fs = 0, last_rise = 0, bad_period = 0, bad_lrck = 0;
   logic [15:0] acc_l = '0, acc_r = '0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (reset || !mon_en) begin
         prev_bclk = 1'b0; active = 0; pend_k0 = 0; have_fs = 0; have_rise = 0;
      end else begin
         if (frame_start) begin
            if (have_fs) check("frame_period", cyc - last_fs, FRAME_CLK);
            have_fs = 1; last_fs = cyc; uf_next = underrun; pend_k0 = 1;
            check("lrck_at_frame_start", lrck, 0);
         end
         if (!prev_bclk && bclk) begin
            if (have_rise && (cyc - last_rise) != 2 * BCLK_HALF) bad_period++;
            have_rise = 1; last_rise = cyc;
            if (pend_k0) begin
               pend_k0 = 0;
               if (active) begin
                  acc_r[0] = sdata;
                  if (exp_q.size() == 0) begin
                     check("exp_queue_nonempty", exp_q.size(), 1);
                  end else begin
                     mon_e = exp_q.pop_front();
                     check("frame_left", acc_l, mon_e.l);
                     check("frame_right", acc_r, mon_e.r);
                     check("frame_underrun", cur_uf, mon_e.uf);
                  end
                  check("frame_lrck", bad_lrck, 0);
                  check("bclk_period", bad_period, 0);
                  frames_checked++;
               end else begin
                  check("first_k0_bit", sdata, 0);
               end
               active = 1; k = 1; cur_uf = uf_next; bad_period = 0;
               bad_lrck = (lrck !== 1'b0) ? 1 : 0;
            end else if (active) begin
               if (k <= DATA_W) acc_l[DATA_W - k] = sdata;
               else             acc_r[2 * DATA_W - k] = sdata;
               if (lrck !== (k >= DATA_W)) bad_lrck++;
               k++;
            end
         end
         prev_bclk = bclk;
      end
   end

   task automatic wait_fs(input int bound);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!frame_start && t < bound);
      check("frame_start_seen", frame_start, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int   fall_e;
      logic prevb;
      int   n_acc, last_acc, t;

      // First run: let a frame start, queue a pair, then reset mid-frame.
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_fs(50);
      check("first_frame_underrun", underrun, 1);
      @(negedge clk);
      in_valid = 1'b1; in_left = 16'h1111; in_right = 16'h2222;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_full_ready_low", in_ready, 0);
      repeat (30) @(negedge clk);
      #2 reset = 1'b1;
      #1 check("async_reset_outputs", {bclk, lrck, sdata, in_ready, frame_start, underrun}, 6'b010100);
      repeat (2) @(negedge clk);

      // Release and load 7FFF/8000 ahead of the first frame.
      reset = 1'b0; mon_en = 1'b1;
      in_valid = 1'b1; in_left = 16'h7FFF; in_right = 16'h8000;
      fall_e = 0; prevb = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin
            exp_q.push_back({16'h7FFF, 16'h8000, 1'b0});
            check("accept_ready_drop", in_ready, 0);
            in_left = 16'hA5C3; in_right = 16'h3C5A;
         end
         if (e == 2) check("bclk_high_edge2", bclk, 1);
         if (prevb && !bclk && fall_e == 0) fall_e = e;
         prevb = bclk;
      end
      check("first_fall_edge", fall_e, 4);
      check("first_frame_lrck_fs_uf", {lrck, frame_start, underrun}, 3'b010);

      // Continuous valid: one accept per frame.
      n_acc = 0; last_acc = 0; t = 0;
      while (n_acc < 4 && t < 1000) begin
         @(negedge clk); t++;
         if (frame_start) check("ready_at_frame_start", in_ready, 1);
         if (in_valid && in_ready) begin
            exp_q.push_back({in_left, in_right, 1'b0});
            n_acc++;
            @(posedge clk); #1;
            if (n_acc > 1) check("accept_interval", cyc - last_acc, FRAME_CLK);
            last_acc = cyc;
            check("ready_drop", in_ready, 0);
            if (n_acc == 3) begin in_left = 16'h8001; in_right = 16'h0001; end
            if (n_acc == 4) in_valid = 1'b0;
         end
      end
      check("accept_count", n_acc, 4);

      // Starve two frames.
      exp_q.push_back({16'h0000, 16'h0000, 1'b1});
      exp_q.push_back({16'h0000, 16'h0000, 1'b1});
      wait_fs(300);
      wait_fs(300);
      check("starved_underrun", underrun, 1);
      @(negedge clk);
      check("underrun_pulse_width", underrun, 0);
      wait_fs(300);

      // Present a pair exactly on the next (empty) frame-load edge.
      repeat (FRAME_CLK - 1) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b1; in_left = 16'h1234; in_right = 16'h5678;
      exp_q.push_back({16'h0000, 16'h0000, 1'b1});
      exp_q.push_back({16'h1234, 16'h5678, 1'b0});
      exp_q.push_back({16'h0000, 16'h0000, 1'b1});
      @(posedge clk); #1;
      check("simul_load_underrun", {frame_start, underrun}, 2'b11);
      check("simul_accept", in_ready, 0);
      in_valid = 1'b0;

      t = 0;
      while (frames_checked < 9 && t < 600) begin
         @(negedge clk); t++;
      end
      check("frames_checked", frames_checked, 9);
      check("queue_remaining", exp_q.size(), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
